// File: rtl/delay_estimator.sv
// Purpose: measures the 1..15 cycle delay between data_i and data_delayed_i, then tracks lock on it.
// Latency: result registered 15+WINDOW cycles after start_i is sampled; lost_o one cycle after the final miss.
// Backpressure: none; the block observes both streams every cycle and never stalls them.
module delay_estimator #(
  parameter int WINDOW      = 32,
  parameter int LOSS_THRESH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       data_i,
  input  logic       data_delayed_i,
  output logic [3:0] delay_o,
  output logic       delay_valid_o,
  output logic       ambiguous_o,
  output logic       no_match_o,
  output logic       lost_o,
  output logic       busy_o
);

  localparam int CW = $clog2(WINDOW + 16);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(14);
  localparam logic [CW-1:0] MEAS_LAST = CW'(WINDOW - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_THRESH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_MEASURE = 3'd2,
    S_DONE    = 3'd3,
    S_TRACK   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [14:0]     r_hist;     // r_hist[k-1] = data_i from k cycles ago
  logic [14:0]     r_cand;     // r_cand[d-1] = delay d still a candidate
  logic [CW-1:0]   r_cnt;
  logic [MW-1:0]   r_miss;
  logic [3:0]      r_delay;
  logic            r_valid;
  logic            r_amb;
  logic            r_nomatch;
  logic            r_lost;

  logic [14:0]     w_match;
  logic [15:0]     w_match_ext;
  logic [14:0]     w_cand_upd;
  logic [3:0]      w_low;
  logic            w_cand_multi;
  logic            w_trk_ok;
  logic            w_fill_last;
  logic            w_meas_last;
  logic            w_loss;

  assign w_match      = ~(r_hist ^ {15{data_delayed_i}});
  // Bit 0 is a dummy slot so delay_o can index directly without a subtract.
  assign w_match_ext  = {w_match, 1'b0};
  assign w_cand_upd   = r_cand & w_match;
  assign w_cand_multi = |(w_cand_upd & (w_cand_upd - 15'd1));
  assign w_trk_ok     = w_match_ext[r_delay];
  assign w_fill_last  = (r_cnt == FILL_LAST);
  assign w_meas_last  = (r_cnt == MEAS_LAST);
  assign w_loss       = !w_trk_ok && (r_miss >= MISS_LAST);

  // Lowest surviving candidate wins; scan from the top so the lowest index is written last.
  always_comb begin
    w_low = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (w_cand_upd[i]) w_low = 4'(i + 1);
    end
  end

  // Next-state selection; start_i outranks loss of lock in TRACK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_state_nxt = S_FILL;
      S_FILL:    if (w_fill_last) w_state_nxt = S_MEASURE;
      S_MEASURE: if (w_meas_last) w_state_nxt = (w_cand_upd == 15'd0) ? S_DONE : S_TRACK;
      S_DONE:    if (start_i) w_state_nxt = S_FILL;
      S_TRACK: begin
        if (start_i)     w_state_nxt = S_FILL;
        else if (w_loss) w_state_nxt = S_MEASURE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Reference history shifts every cycle regardless of state so a relock needs no refill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_hist <= 15'd0;
    else        r_hist <= {r_hist[13:0], data_i};
  end

  // Counters, candidate mask and registered results.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cand    <= 15'd0;
      r_cnt     <= '0;
      r_miss    <= '0;
      r_delay   <= 4'd0;
      r_valid   <= 1'b0;
      r_amb     <= 1'b0;
      r_nomatch <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_cnt     <= '0;
            r_delay   <= 4'd0;
            r_valid   <= 1'b0;
            r_amb     <= 1'b0;
            r_nomatch <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_fill_last) begin
            r_cnt  <= '0;
            r_cand <= 15'h7FFF;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_MEASURE: begin
          r_cand <= w_cand_upd;
          if (w_meas_last) begin
            r_cnt     <= '0;
            r_miss    <= '0;
            r_delay   <= w_low;
            r_valid   <= (w_cand_upd != 15'd0);
            r_amb     <= w_cand_multi;
            r_nomatch <= (w_cand_upd == 15'd0);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_TRACK: begin
          if (start_i) begin
            r_cnt     <= '0;
            r_miss    <= '0;
            r_delay   <= 4'd0;
            r_valid   <= 1'b0;
            r_amb     <= 1'b0;
            r_nomatch <= 1'b0;
          end else if (w_trk_ok) begin
            r_miss <= '0;
          end else if (w_loss) begin
            r_lost  <= 1'b1;
            r_cnt   <= '0;
            r_miss  <= '0;
            r_cand  <= 15'h7FFF;
            r_delay <= 4'd0;
            r_valid <= 1'b0;
            r_amb   <= 1'b0;
          end else begin
            r_miss <= r_miss + MW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign delay_o       = r_delay;
  assign delay_valid_o = r_valid;
  assign ambiguous_o   = r_amb;
  assign no_match_o    = r_nomatch;
  assign lost_o        = r_lost;
  assign busy_o        = (r_state == S_FILL) || (r_state == S_MEASURE);

endmodule

// File: tb/tb_delay_estimator.sv
// Bench for delay_estimator: drives a modelled programmable delay line with random data
// and compares every result against a window-scan reference computed from logged streams.
module tb_delay_estimator;

  localparam int W = 32;
  localparam int LOGN = 8192;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       data_i;
  logic       data_delayed_i;
  logic [3:0] delay_o;
  logic       delay_valid_o;
  logic       ambiguous_o;
  logic       no_match_o;
  logic       lost_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  delay_estimator #(.WINDOW(W), .LOSS_THRESH(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .data_i         (data_i),
    .data_delayed_i (data_delayed_i),
    .delay_o        (delay_o),
    .delay_valid_o  (delay_valid_o),
    .ambiguous_o    (ambiguous_o),
    .no_match_o     (no_match_o),
    .lost_o         (lost_o),
    .busy_o         (busy_o)
  );

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  int mode = 0;   // 0: delayed copy, 1: constant zero, 2: inverted copy at 5
  int dprog = 1;
  bit din_log [LOGN];
  bit dd_log  [LOGN];

  typedef struct {
    int dly;
    int amb;
    int nm;
  } res_t;

  typedef struct {
    int mode;
    int dprog;
    int e_dly;
    int e_vld;
    int e_amb;
    int e_nm;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s actual %0d expected %0d at cycle %0d", name, act, exp, ncyc);
    end
  endtask

  function automatic bit din_at(input int c);
    if (c < 0) return 1'b0;
    return din_log[c];
  endfunction

  // Reference: delay d survives if every window sample satisfies dd(c) == din(c-d).
  function automatic res_t model(input int c0);
    res_t r;
    int   cnt;
    bit   ok;
    r.dly = 0;
    cnt   = 0;
    for (int d = 1; d <= 15; d++) begin
      ok = 1'b1;
      for (int c = c0; c < c0 + W; c++) begin
        if (dd_log[c] != din_at(c - d)) ok = 1'b0;
      end
      if (ok) begin
        cnt++;
        if (r.dly == 0) r.dly = d;
      end
    end
    r.amb = (cnt > 1) ? 1 : 0;
    r.nm  = (cnt == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic drive(input bit st);
    bit d;
    bit dd;
    d = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    din_log[ncyc] = d;
    dd = (mode == 2) ? ~din_at(ncyc - 5) : din_at(ncyc - dprog);
    dd_log[ncyc]   = dd;
    data_i         = d;
    data_delayed_i = dd;
    start_i        = st;
  endtask

  task automatic clk_step();
    @(posedge clk_i);
    #1;
    ncyc++;
    if (ncyc >= LOGN - 2) begin
      $display("FAIL cycle_budget actual %0d expected below %0d", ncyc, LOGN - 2);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic tick(input bit st);
    drive(st);
    clk_step();
  endtask

  task automatic check_outs(input string tag, input res_t r);
    chk({tag, "_dly"},   int'(delay_o),       r.dly);
    chk({tag, "_vld"},   int'(delay_valid_o), (r.nm == 0) ? 1 : 0);
    chk({tag, "_amb"},   int'(ambiguous_o),   r.amb);
    chk({tag, "_nm"},    int'(no_match_o),    r.nm);
    chk({tag, "_busy"},  int'(busy_o),        0);
  endtask

  // Start pulse, run to the expected result edge, compare with the model.
  // ign_at >= 0 re-asserts start_i on cycle cs+1+ign_at, which must be ignored.
  task automatic measure(input string tag, input int ign_at, output res_t r);
    int cs;
    cs = ncyc;
    tick(1'b1);
    for (int i = 0; i < 15 + W - 1; i++) tick(i == ign_at);
    chk({tag, "_pre_vld"},  int'(delay_valid_o), 0);
    chk({tag, "_pre_busy"}, int'(busy_o),        1);
    tick(1'b0);
    r = model(cs + 16);
    check_outs(tag, r);
  endtask

  initial begin
    vec_t tbl [5];
    res_t r;
    int   consec;
    int   lost_c;
    int   cs;
    bit   mm;
    bit   done;

    tbl[0] = '{0, 7,  7,  1, 0, 0};
    tbl[1] = '{1, 0,  1,  1, 1, 0};
    tbl[2] = '{2, 0,  0,  0, 0, 1};
    tbl[3] = '{0, 1,  1,  1, 0, 0};
    tbl[4] = '{0, 15, 15, 1, 0, 0};

    rst_i = 1'b0;
    start_i = 1'b0;
    data_i = 1'b0;
    data_delayed_i = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("rst_dly",  int'(delay_o),       0);
    chk("rst_vld",  int'(delay_valid_o), 0);
    chk("rst_amb",  int'(ambiguous_o),   0);
    chk("rst_nm",   int'(no_match_o),    0);
    chk("rst_lost", int'(lost_o),        0);
    chk("rst_busy", int'(busy_o),        0);
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b0);
    chk("idle_busy", int'(busy_o), 0);

    // Table rows: explicit expectations plus the model cross-check inside measure.
    for (int k = 0; k < 5; k++) begin
      mode  = tbl[k].mode;
      dprog = tbl[k].dprog;
      measure($sformatf("row%0d", k), -1, r);
      chk($sformatf("row%0d_tbl_dly", k), int'(delay_o),       tbl[k].e_dly);
      chk($sformatf("row%0d_tbl_vld", k), int'(delay_valid_o), tbl[k].e_vld);
      chk($sformatf("row%0d_tbl_amb", k), int'(ambiguous_o),   tbl[k].e_amb);
      chk($sformatf("row%0d_tbl_nm",  k), int'(no_match_o),    tbl[k].e_nm);
      if (tbl[k].e_nm != 0) begin
        for (int i = 0; i < 5; i++) tick(1'b0);
        chk("done_hold_nm",   int'(no_match_o), 1);
        chk("done_hold_busy", int'(busy_o),     0);
      end
    end

    // Sweep every programmable delay.
    mode = 0;
    for (int d = 1; d <= 15; d++) begin
      dprog = d;
      measure($sformatf("sweep%0d", d), -1, r);
      chk($sformatf("sweep%0d_prog", d), int'(delay_o), d);
    end

    // Lock at 7, reprogram to 3, expect loss after two consecutive misses, then relock.
    dprog = 7;
    measure("lock7", -1, r);
    chk("lock7_prog", int'(delay_o), 7);
    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("lock7_hold_vld",  int'(delay_valid_o), 1);
    chk("lock7_hold_lost", int'(lost_o),        0);
    dprog  = 3;
    consec = 0;
    lost_c = -1;
    for (int i = 0; i < 200 && lost_c < 0; i++) begin
      drive(1'b0);
      mm = (dd_log[ncyc] != din_at(ncyc - 7));
      clk_step();
      consec = mm ? consec + 1 : 0;
      if (consec >= 2) begin
        lost_c = ncyc - 1;
        chk("loss_lost", int'(lost_o),        1);
        chk("loss_vld",  int'(delay_valid_o), 0);
        chk("loss_dly",  int'(delay_o),       0);
        chk("loss_busy", int'(busy_o),        1);
      end else begin
        chk("track_lost", int'(lost_o),        0);
        chk("track_vld",  int'(delay_valid_o), 1);
      end
    end
    if (lost_c < 0) begin
      chk("loss_timeout", 0, 1);
    end else begin
      tick(1'b0);
      chk("lost_one_cycle", int'(lost_o), 0);
      for (int i = 0; i < W - 1; i++) tick(1'b0);
      r = model(lost_c + 1);
      check_outs("relock", r);
      chk("relock_prog", int'(delay_o), 3);
    end

    // Start arriving in the same cycle as the loss-causing miss wins; no lost pulse.
    dprog  = 9;
    consec = 0;
    done   = 1'b0;
    cs     = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      drive(1'b0);
      mm = (dd_log[ncyc] != din_at(ncyc - 3));
      if (consec == 1 && mm) begin
        start_i = 1'b1;
        cs = ncyc;
        clk_step();
        chk("prio_lost", int'(lost_o),        0);
        chk("prio_busy", int'(busy_o),        1);
        chk("prio_vld",  int'(delay_valid_o), 0);
        chk("prio_dly",  int'(delay_o),       0);
        done = 1'b1;
      end else begin
        clk_step();
        consec = mm ? consec + 1 : 0;
        chk("prio_track_vld", int'(delay_valid_o), 1);
      end
    end
    if (!done) begin
      chk("prio_timeout", 0, 1);
    end else begin
      for (int i = 0; i < 15 + W; i++) tick(1'b0);
      r = model(cs + 16);
      check_outs("prio_meas", r);
      chk("prio_meas_prog", int'(delay_o), 9);
    end

    // Reset in the middle of MEASURE, then a restart with an ignored second start.
    mode  = 0;
    dprog = 4;
    tick(1'b1);
    for (int i = 0; i < 19; i++) tick(1'b0);
    chk("mid_busy", int'(busy_o), 1);
    rst_i = 1'b0;
    #1;
    chk("arst_dly",  int'(delay_o),       0);
    chk("arst_vld",  int'(delay_valid_o), 0);
    chk("arst_amb",  int'(ambiguous_o),   0);
    chk("arst_nm",   int'(no_match_o),    0);
    chk("arst_lost", int'(lost_o),        0);
    chk("arst_busy", int'(busy_o),        0);
    tick(1'b0);
    tick(1'b0);
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("post_rst_busy", int'(busy_o),        0);
    chk("post_rst_vld",  int'(delay_valid_o), 0);
    measure("restart", 19, r);
    chk("restart_prog", int'(delay_o), 4);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
